// File: rtl/result_display.sv
// Divider result display: registers a quotient/remainder pair and scans it onto a
// 4-digit active-low seven-segment display as "QQ.RR". Optional macro: DIV_ZERO_ERR_EN.
module result_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] quotient,
  input  logic [3:0] remainder,
  input  logic       div_zero,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       valid
);

  localparam int            CW      = $clog2(SCAN_DIV) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    q_r;
  logic [3:0]    r_r;
  logic          err_s;
  logic [6:0]    seg_s;
  logic          dp_s;
  logic          q_tens_s;
  logic          r_tens_s;
  logic [3:0]    q_units_s;
  logic [3:0]    r_units_s;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] units_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

`ifdef DIV_ZERO_ERR_EN
  logic z_r;

  // Divide-by-zero flag, captured alongside the result
  always_ff @(posedge clk) begin
    if (reset) begin
      z_r <= 1'b0;
    end else if (load) begin
      z_r <= div_zero;
    end else begin
      z_r <= z_r;
    end
  end

  assign err_s = z_r;
`else
  logic unused_div_zero_s;
  assign unused_div_zero_s = div_zero;
  assign err_s             = 1'b0;
`endif

  assign q_tens_s  = (q_r >= 4'd10);
  assign r_tens_s  = (r_r >= 4'd10);
  assign q_units_s = units_of(q_r);
  assign r_units_s = units_of(r_r);

  // Digit content for the currently selected position
  always_comb begin
    seg_s = SEG_BLANK;
    dp_s  = 1'b1;
    if (!valid) begin
      seg_s = SEG_BLANK;
    end else if (err_s) begin
      case (idx)
        2'd2:    seg_s = SEG_E;
        2'd1:    seg_s = SEG_R;
        2'd0:    seg_s = SEG_R;
        default: seg_s = SEG_BLANK;
      endcase
    end else begin
      case (idx)
        2'd3:    seg_s = q_tens_s ? seg_code(4'd1) : SEG_BLANK;
        2'd2: begin
          seg_s = seg_code(q_units_s);
          dp_s  = 1'b0;
        end
        2'd1:    seg_s = r_tens_s ? seg_code(4'd1) : SEG_BLANK;
        2'd0:    seg_s = seg_code(r_units_s);
        default: seg_s = SEG_BLANK;
      endcase
    end
  end

  // Scan counter, holding registers and registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= 2'd0;
      q_r   <= 4'd0;
      r_r   <= 4'd0;
      valid <= 1'b0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
      end
      if (load) begin
        q_r   <= quotient;
        r_r   <= remainder;
        valid <= 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display with SCAN_DIV=4: the driver pushes the
// hand-computed expected output of each edge, a monitor pops and compares it.
module tb_result_display;

  localparam int SD = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       valid;
  } exp_t;

  localparam logic [6:0] BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] quotient = 4'd0;
  logic [3:0] remainder = 4'd0;
  logic       div_zero = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       valid;

  exp_t       sb_q[$];
  int         tests = 0;
  int         fails = 0;
  int         pos   = 0;
  logic       exp_valid = 1'b0;
  logic [6:0] shown[4];
  logic       shown_dp2 = 1'b1;

  result_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .load(load), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero),
    .an(an), .seg(seg), .dp(dp), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic set_show(input logic [6:0] s3, input logic [6:0] s2,
                          input logic [6:0] s1, input logic [6:0] s0,
                          input logic dp2);
    shown[3] = s3; shown[2] = s2; shown[1] = s1; shown[0] = s0;
    shown_dp2 = dp2;
  endtask

  // One clock: drive inputs at negedge and push the expectation for the coming edge
  task automatic cyc(input logic rst, input logic ld, input logic [3:0] q,
                     input logic [3:0] r, input logic dz);
    exp_t e;
    int   i;
    @(negedge clk);
    reset = rst; load = ld; quotient = q; remainder = r; div_zero = dz;
    if (rst) begin
      e = '{an: 4'b1111, seg: BL, dp: 1'b1, valid: 1'b0};
      exp_valid = 1'b0;
      pos = 0;
      set_show(BL, BL, BL, BL, 1'b1);
    end else begin
      i = (pos / SD) % 4;
      e.an  = ~(4'b0001 << i);
      e.seg = shown[i];
      e.dp  = (i == 2) ? shown_dp2 : 1'b1;
      if (ld) exp_valid = 1'b1;
      e.valid = exp_valid;
      pos++;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  // Monitor: compare every registered output update against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests++;
        if ({an, seg, dp, valid} !== e) begin
          fails++;
          $display("FAIL out t=%0t: got an=%b seg=%b dp=%b valid=%b, want an=%b seg=%b dp=%b valid=%b",
                   $time, an, seg, dp, valid, e.an, e.seg, e.dp, e.valid);
        end
      end
    end
  end

  initial begin
    set_show(BL, BL, BL, BL, 1'b1);
    // Reset held, then blank scan
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    idle(16);

    // 13 / 2 -> "13.02" shown as "1" "3." blank "2"
    cyc(1'b0, 1'b1, 4'd13, 4'd2, 1'b0);
    set_show(7'b1111001, 7'b0110000, BL, 7'b0100100, 1'b0);
    idle(16);

    // 0 / 15 -> blank "0." "1" "5"
    cyc(1'b0, 1'b1, 4'd0, 4'd15, 1'b0);
    set_show(BL, 7'b1000000, 7'b1111001, 7'b0010010, 1'b0);
    idle(16);

    // Divide by zero with q=5
    cyc(1'b0, 1'b1, 4'd5, 4'd0, 1'b1);
`ifdef DIV_ZERO_ERR_EN
    set_show(BL, 7'b0000110, 7'b0101111, 7'b0101111, 1'b1);
`else
    set_show(BL, 7'b0010010, BL, 7'b1000000, 1'b0);
`endif
    idle(16);
    cyc(1'b0, 1'b1, 4'd5, 4'd0, 1'b0);
    set_show(BL, 7'b0010010, BL, 7'b1000000, 1'b0);
    idle(16);

    // Reset while digit 2 is lit
    while (((pos / SD) % 4) != 2) idle(1);
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    idle(8);

    // Load with reset on the same edge: reset wins
    cyc(1'b1, 1'b1, 4'd9, 4'd9, 1'b0);
    idle(8);

    // Load exactly on an idx wrap edge: 7 / 9 -> blank "7." blank "9"
    while ((pos % SD) != SD - 1) idle(1);
    cyc(1'b0, 1'b1, 4'd7, 4'd9, 1'b0);
    set_show(BL, 7'b1111000, BL, 7'b0010000, 1'b0);
    idle(20);

    // 10 / 11 -> "1" "0." "1" "1"
    cyc(1'b0, 1'b1, 4'd10, 4'd11, 1'b0);
    set_show(7'b1111001, 7'b1000000, 7'b1111001, 7'b1111001, 1'b0);
    idle(16);

    @(posedge clk);
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_display.md
# result_display

Downstream presentation stage for the calculator's 4-bit divider. Registers a quotient/remainder pair on a load strobe, converts each 0–15 value to two decimal digits, and drives a time-multiplexed 4-digit active-low seven-segment display. Layout is "QQ.RR": the quotient is on the left and the remainder on the right. An optional divide-by-zero error message is available.

## Interface
- SCAN_DIV, 50000, clock cycles each digit stays lit; legal range 1..2^20; counter width is $clog2(SCAN_DIV)+1
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- load  input  1  capture strobe; samples quotient/remainder/div_zero on the edge where high
- quotient  input  4  unsigned divider quotient
- remainder  input  4  unsigned divider remainder
- div_zero  input  1  high when the operation's divisor was 0
- an  output  4  digit enables, active-low; an[3] is leftmost
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- valid  output  1  high once a result has been captured since reset

## Operation
- Holding registers: q_r[3:0], r_r[3:0], z_r, valid. Every clk edge with load=1 and reset=0 overwrites q_r, r_r and z_r, and sets valid=1. There is no back-pressure; a new load always replaces the old result.
- Scan counter: cnt counts 0..SCAN_DIV-1. When cnt reaches SCAN_DIV-1, cnt returns to 0 and the digit index idx[1:0] increments, wrapping 3→0. With SCAN_DIV=1, idx advances every cycle. load never disturbs cnt or idx.
- Decimal split for a value v: tens = (v≥10), units = v≥10 ? v−10 : v.
- Digit contents by idx:
  - idx 3 = quotient tens
  - idx 2 = quotient units, with dp lit
  - idx 1 = remainder tens
  - idx 0 = remainder units
- A tens digit equal to 0 is blanked (leading-zero suppression). Units digits always show.
- Segment codes, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, E=0000110, r=0101111
- When valid=0, an still scans but seg=blank and dp=1.
- an = ~(4'b0001 << idx), registered.

## Timing
- Reset, and the first edge with reset=1: an=1111, seg=1111111, dp=1, valid=0, cnt=0, idx=0, q_r=r_r=0, z_r=0.
- First edge after reset deasserts: an=1110.
- Outputs are registered and derived from the current idx and holding registers. Latency: seg/dp show the new data on the edge after load is sampled, provided the lit digit is the one being checked.
- Reset dominates load when both are high on the same edge.
- Reset mid-scan zeroes cnt and idx immediately and blanks the display.
- load on the same edge as an idx wrap: both take effect. The next output update shows the new data on the new digit.
- Back-to-back loads: the last one wins. No intermediate value needs to be visible.

## Configuration
- DIV_ZERO_ERR_EN defined:
  - When z_r=1 and valid=1, the display reads " Err": idx3 blank, idx2 E, idx1 r, idx0 r, dp=1 on all digits.
  - q_r and r_r are ignored while z_r=1.
  - The next load with div_zero=0 restores normal display.
- DIV_ZERO_ERR_EN not defined:
  - The div_zero input is ignored and z_r is not implemented.
  - quotient/remainder are shown as captured, whatever they are.

## Test plan
- Reset held 3 cycles → an=1111, seg=1111111, dp=1, valid=0. Release with SCAN_DIV=4 → an=1110, 1101, 1011, 0111, each held 4 cycles, seg blank throughout.
- load with q=13, r=2 → valid=1. Over one scan: idx3 seg=1111001 ("1"); idx2 seg=0110000 ("3") with dp=0; idx1 blank; idx0 seg=0100100 ("2").
- load with q=0, r=15 → idx3 blank; idx2 "0" with dp=0; idx1 "1"; idx0 "5".
- Macro defined: load with div_zero=1, q=5 → " Err" sequence with dp=1. Next load with q=5, r=0, div_zero=0 → blank "5." blank "0". Macro undefined: the same div_zero=1 stimulus shows blank "5." blank "0".
- reset asserted while idx=2 and valid=1 → next edge an=1111, seg blank, valid=0. Scan restarts at idx 0.
- load and reset high on the same edge → reset wins and valid stays 0. load asserted exactly on an idx wrap edge → the new digit shows the new data on the following edge; scan period unchanged.
